// File: rtl/input_vc_arbiter_if.sv
// Handshake bundle between the per-VC input buffers / switch allocator and
// the input VC arbiter. The arbiter connects through the slave modport.
interface input_vc_arbiter_if #(
  parameter int vc_num     = 3,
  parameter int prio_num   = 2,
  parameter int output_num = 8
);
  localparam int v  = vc_num * prio_num;
  localparam int vw = (v > 1) ? $clog2(v) : 1;

  // Upstream side: VC occupancy and head-packet routing info, allocator handshake
  logic [v-1:0]                 i_has_packet;
  logic [v-1:0][output_num-1:0] i_dest;
  logic [v-1:0][vw-1:0]         i_output_vc;
  logic                         i_cts;
  logic                         i_last;

  // Arbiter side: registered request / grant status and latched route
  logic                         o_request;
  logic                         o_granted;
  logic [vw-1:0]                o_selected_vc;
  logic [output_num-1:0]        o_dest;
  logic [vw-1:0]                o_output_vc;

  modport master (
    output i_has_packet, i_dest, i_output_vc, i_cts, i_last,
    input  o_request, o_granted, o_selected_vc, o_dest, o_output_vc
  );

  modport slave (
    input  i_has_packet, i_dest, i_output_vc, i_cts, i_last,
    output o_request, o_granted, o_selected_vc, o_dest, o_output_vc
  );
endinterface

// File: rtl/input_vc_arbiter.sv
// Per-input-port VC arbiter: strict priority across classes, round-robin
// within a class. Holds the selected VC from request through the last beat
// of its packet, then returns to IDLE for one bubble before the next pick.
module input_vc_arbiter #(
  parameter int vc_num     = 3,
  parameter int prio_num   = 2,
  parameter int output_num = 8
) (
  input  logic                clk,
  input  logic                reset,
  input_vc_arbiter_if.slave   bus
);
  localparam int v  = vc_num * prio_num;
  localparam int vw = (v > 1) ? $clog2(v) : 1;
  localparam int pw = (vc_num > 1) ? $clog2(vc_num) : 1;
  localparam int cw = (prio_num > 1) ? $clog2(prio_num) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANTED = 2'd2
  } state_t;

  state_t        state;
  logic [pw-1:0] rr_ptr [prio_num];
  logic [cw-1:0] sel_class;
  logic [pw-1:0] sel_local;

  logic          found;
  logic [vw-1:0] win_vc;
  logic [cw-1:0] win_class;
  logic [pw-1:0] win_local;

  // Winner search: highest non-empty class, then first requester at or after
  // that class's pointer with an explicit wrap at vc_num.
  always_comb begin
    int loc;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    found     = 1'b0;
    win_vc    = '0;
    win_class = '0;
    win_local = '0;
    loc       = 0;
    for (int c = prio_num - 1; c >= 0; c--) begin
      for (int k = 0; k < vc_num; k++) begin
        loc = int'(rr_ptr[c]) + k;
        if (loc >= vc_num) loc = loc - vc_num;
        if (!found && bus.i_has_packet[c * vc_num + loc]) begin
          found     = 1'b1;
          win_vc    = vw'(c * vc_num + loc);
          win_class = cw'(c);
          win_local = pw'(loc);
        end
      end
    end
  end

  // Arbiter FSM with registered outputs and per-class round-robin pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      bus.o_request     <= 1'b0;
      bus.o_granted     <= 1'b0;
      bus.o_selected_vc <= '0;
      bus.o_dest        <= '0;
      bus.o_output_vc   <= '0;
      sel_class         <= '0;
      sel_local         <= '0;
      // NOTE: rr_ptr is a handful of flops, not a RAM, so clearing it in reset is intended.
      for (int c = 0; c < prio_num; c++) rr_ptr[c] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop update tied to the same clock edge.
      unique case (state)
        IDLE: begin
          if (found) begin
            state             <= REQ;
            bus.o_request     <= 1'b1;
            bus.o_selected_vc <= win_vc;
            bus.o_dest        <= bus.i_dest[win_vc];
            bus.o_output_vc   <= bus.i_output_vc[win_vc];
            sel_class         <= win_class;
            sel_local         <= win_local;
          end
        end
        REQ: begin
          if (bus.i_cts) begin
            state         <= GRANTED;
            bus.o_request <= 1'b0;
            bus.o_granted <= 1'b1;
          end else if (!bus.i_has_packet[bus.o_selected_vc]) begin
            // Head packet vanished before grant: withdraw, pointer untouched
            state             <= IDLE;
            bus.o_request     <= 1'b0;
            bus.o_selected_vc <= '0;
            bus.o_dest        <= '0;
            bus.o_output_vc   <= '0;
          end
        end
        GRANTED: begin
          if (bus.i_last) begin
            state             <= IDLE;
            bus.o_granted     <= 1'b0;
            bus.o_selected_vc <= '0;
            bus.o_dest        <= '0;
            bus.o_output_vc   <= '0;
            rr_ptr[sel_class] <= (sel_local == pw'(vc_num - 1)) ? '0 : sel_local + 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.o_request <= 1'b0;
          bus.o_granted <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_input_vc_arbiter.sv
// Testbench for input_vc_arbiter: directed stimulus, scoreboard of expected
// requests checked by an independent monitor on each new request.
module tb_input_vc_arbiter;
  logic clk;
  logic reset;

  input_vc_arbiter_if #(.vc_num(3), .prio_num(2), .output_num(8)) bus ();

  input_vc_arbiter #(.vc_num(3), .prio_num(2), .output_num(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         vc;
    logic [7:0] dest;
    int         ovc;
  } exp_t;

  exp_t       sb [$];
  int         tests = 0;
  int         fails = 0;
  logic       prev_req = 1'b0;

  logic [7:0] dest_tab [6] = '{8'h01, 8'h02, 8'h10, 8'h08, 8'h20, 8'h40};
  int         ovc_tab  [6] = '{1, 3, 2, 5, 0, 4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int vc);
    exp_t e;
    e.vc   = vc;
    e.dest = dest_tab[vc];
    e.ovc  = ovc_tab[vc];
    sb.push_back(e);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.o_request && n < 5) begin
      step();
      n++;
    end
    check("req_seen", 32'(bus.o_request), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // One full packet on the expected VC: request, cts, grant, last, idle
  task automatic packet(input int vc);
    push(vc);
    wait_req();
    check("sel_vc", 32'(bus.o_selected_vc), 32'(vc));
    bus.i_cts = 1'b1;
    step();
    bus.i_cts = 1'b0;
    check("granted", 32'(bus.o_granted), 32'd1);
    check("sel_hold", 32'(bus.o_selected_vc), 32'(vc));
    bus.i_last = 1'b1;
    step();
    bus.i_last = 1'b0;
    check("idle_after_last", 32'({bus.o_granted, bus.o_request}), 32'd0);
  endtask

  // Monitor: each new request is compared against the oldest expectation
  always @(negedge clk) begin
    if (!reset && bus.o_request && !prev_req) begin
      if (sb.size() == 0) begin
        check("unexpected_req", 32'(bus.o_selected_vc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mon_vc", 32'(bus.o_selected_vc), 32'(e.vc));
        check("mon_dest", 32'(bus.o_dest), 32'(e.dest));
        check("mon_ovc", 32'(bus.o_output_vc), 32'(e.ovc));
      end
    end
    prev_req = bus.o_request;
  end

  initial begin
    reset            = 1'b1;
    bus.i_has_packet = '0;
    bus.i_cts        = 1'b0;
    bus.i_last       = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.i_dest[i]      = dest_tab[i];
      bus.i_output_vc[i] = 3'(ovc_tab[i]);
    end

    // Reset state
    step();
    step();
    check("rst_request", 32'(bus.o_request), 32'd0);
    check("rst_granted", 32'(bus.o_granted), 32'd0);
    check("rst_sel", 32'(bus.o_selected_vc), 32'd0);
    check("rst_dest", 32'(bus.o_dest), 32'd0);
    check("rst_ovc", 32'(bus.o_output_vc), 32'd0);
    reset = 1'b0;

    // Single request on VC2, one-cycle latency, frozen outputs, ignored events
    push(2);
    bus.i_has_packet = 6'b000100;
    step();
    check("req_latency", 32'(bus.o_request), 32'd1);
    bus.i_dest[2]      = 8'hFF;
    bus.i_output_vc[2] = 3'd7;
    step();
    check("frozen_dest", 32'(bus.o_dest), 32'h10);
    check("frozen_ovc", 32'(bus.o_output_vc), 32'd2);
    bus.i_dest[2]      = dest_tab[2];
    bus.i_output_vc[2] = 3'(ovc_tab[2]);
    bus.i_last = 1'b1;
    step();
    bus.i_last = 1'b0;
    check("last_in_req_req", 32'(bus.o_request), 32'd1);
    check("last_in_req_gnt", 32'(bus.o_granted), 32'd0);
    bus.i_cts = 1'b1;
    step();
    check("cts_grant", 32'(bus.o_granted), 32'd1);
    bus.i_has_packet = '0;
    step();
    bus.i_cts = 1'b0;
    check("cts_in_granted", 32'(bus.o_granted), 32'd1);
    check("cts_in_granted_req", 32'(bus.o_request), 32'd0);
    bus.i_last = 1'b1;
    step();
    check("last_idle_gnt", 32'(bus.o_granted), 32'd0);
    check("last_idle_dest", 32'(bus.o_dest), 32'd0);
    check("last_idle_sel", 32'(bus.o_selected_vc), 32'd0);
    step();
    bus.i_last = 1'b0;
    check("last_in_idle", 32'(bus.o_request), 32'd0);

    // Strict priority: class 1 beats class 0 while it has a packet
    bus.i_has_packet = 6'b001001;
    packet(3);
    packet(3);
    bus.i_has_packet = 6'b000001;
    packet(0);
    bus.i_has_packet = '0;

    // Round-robin wrap inside class 1 from a cleared pointer
    do_reset();
    bus.i_has_packet = 6'b111000;
    packet(3);
    packet(4);
    packet(5);
    packet(3);
    bus.i_has_packet = '0;

    // Withdraw on VC4 leaves the class-1 pointer at VC4
    bus.i_has_packet = 6'b111000;
    push(4);
    wait_req();
    check("wd_sel", 32'(bus.o_selected_vc), 32'd4);
    bus.i_has_packet = 6'b101000;
    step();
    check("wd_idle", 32'(bus.o_request), 32'd0);
    check("wd_sel_clr", 32'(bus.o_selected_vc), 32'd0);
    bus.i_has_packet = 6'b111000;
    packet(4);
    bus.i_has_packet = '0;

    // cts and last together in REQ: grant taken, last dropped
    bus.i_has_packet = 6'b000010;
    push(1);
    wait_req();
    bus.i_cts  = 1'b1;
    bus.i_last = 1'b1;
    step();
    bus.i_cts  = 1'b0;
    bus.i_last = 1'b0;
    check("cts_last_gnt", 32'(bus.o_granted), 32'd1);
    step();
    check("cts_last_hold", 32'(bus.o_granted), 32'd1);
    bus.i_last = 1'b1;
    step();
    bus.i_last = 1'b0;
    check("cts_last_end", 32'(bus.o_granted), 32'd0);
    bus.i_has_packet = '0;

    // Async reset mid-GRANTED clears outputs and pointers
    bus.i_has_packet = 6'b000011;
    packet(0);
    push(1);
    wait_req();
    check("pre_rst_sel", 32'(bus.o_selected_vc), 32'd1);
    bus.i_cts = 1'b1;
    step();
    bus.i_cts = 1'b0;
    check("pre_rst_gnt", 32'(bus.o_granted), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_gnt", 32'(bus.o_granted), 32'd0);
    check("async_rst_req", 32'(bus.o_request), 32'd0);
    check("async_rst_sel", 32'(bus.o_selected_vc), 32'd0);
    push(0);
    #2;
    reset = 1'b0;
    wait_req();
    check("post_rst_sel", 32'(bus.o_selected_vc), 32'd0);
    bus.i_has_packet = '0;
    bus.i_cts = 1'b1;
    step();
    bus.i_cts  = 1'b0;
    bus.i_last = 1'b1;
    step();
    bus.i_last = 1'b0;
    check("post_rst_idle", 32'({bus.o_granted, bus.o_request}), 32'd0);

    step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/input_vc_arbiter.md
# input_vc_arbiter

Per-input-port VC arbiter that sits directly downstream of the per-VC input buffers and upstream of the switch allocator. Each cycle it sees which of the `vc_num*prio_num` VCs hold a packet. It picks one VC by strict priority class, then round-robin within the class, and presents that VC's destination and output VC as a request. After `cts` it holds the grant until the packet's `last` beat.

## Interface
- `vc_num`, 3, VCs per priority class
- `prio_num`, 2, priority classes; VC index `i` belongs to class `i / vc_num`; class `prio_num-1` is highest
- `output_num`, 8, switch outputs; destination is a one-hot/bitmask vector
- Derived: `V = vc_num*prio_num`, `VW = $clog2(V)`
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `i_has_packet`  in  V  bit i = VC i holds at least one packet
- `i_dest`  in  V x output_num  per-VC destination vector of head packet
- `i_output_vc`  in  V x VW  per-VC requested output VC of head packet
- `i_cts`  in  1  clear-to-send from switch allocator for the current request
- `i_last`  in  1  last beat of the granted packet is transferred this cycle
- `o_request`  out  1  request valid (state REQ)
- `o_granted`  out  1  packet transfer in progress (state GRANTED)
- `o_selected_vc`  out  VW  VC being requested/served
- `o_dest`  out  output_num  latched destination of selected VC
- `o_output_vc`  out  VW  latched output VC of selected VC

## Operation
- FSM states: IDLE, REQ, GRANTED.
- IDLE:
  - If `i_has_packet != 0`, choose winner `w`. Register `o_selected_vc=w`, `o_dest=i_dest[w]` and `o_output_vc=i_output_vc[w]`, then go to REQ.
  - Otherwise stay in IDLE.
- Winner selection:
  - Take the highest class `c` with any requesting VC.
  - Within `c`, take the first requester at or after `rr_ptr[c]`, scanning local indices `rr_ptr[c], rr_ptr[c]+1, … vc_num-1, 0, …` (cyclic wrap).
  - `w = c*vc_num + local`.
- REQ:
  - `o_request=1`.
  - If `i_cts`, go to GRANTED.
  - Else if `i_has_packet[o_selected_vc]==0`, withdraw to IDLE with no pointer update.
  - Else hold.
  - Latched outputs are frozen; `i_dest`/`i_output_vc` changes are ignored.
- GRANTED:
  - `o_granted=1`, `o_request=0`.
  - On `i_last`, set `rr_ptr[c] <= (local+1) mod vc_num` for the served VC, then go to IDLE.
  - `i_has_packet` changes and `i_cts` are ignored.
- `rr_ptr` per class is `$clog2(vc_num)` bits (min 1). Wrap at `vc_num` is explicit and does not rely on power-of-two width. Only the served class's pointer moves.
- `i_last` is ignored outside GRANTED; `i_cts` is ignored outside REQ.
- Reset values: state IDLE; all outputs 0; all `rr_ptr` 0.
- On entering IDLE, `o_dest`, `o_output_vc` and `o_selected_vc` clear to 0.
- Reset mid-packet: return to IDLE at once with outputs 0; the in-flight packet is abandoned (the upstream buffer is reset by the same signal).

## Timing
- `i_has_packet` rises at cycle t (arbiter in IDLE) -> `o_request=1` with valid `o_selected_vc`/`o_dest`/`o_output_vc` at t+1.
- `i_cts` high at cycle t in REQ -> `o_granted=1` at t+1; `o_selected_vc` stays stable from REQ through the end of GRANTED.
- `i_last` at cycle t in GRANTED:
  - `o_granted=0` at t+1 (IDLE); next `o_request` no earlier than t+2.
  - One idle bubble between packets is required.
- Minimum packet occupancy is REQ(1) + GRANTED(1): `cts` and `last` on consecutive cycles.
- `i_cts` and `i_last` both high in REQ: `cts` wins and `last` is dropped.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset / single request:
  - Assert `reset`; all outputs 0.
  - Release; `i_has_packet=6'b000100`, dest `8'h10`, ovc 2.
  - Expect `o_request=1`, `o_selected_vc=2`, `o_dest=8'h10`, `o_output_vc=2` one cycle later.
  - `cts` -> `o_granted=1` next cycle; `last` -> IDLE.
- Strict priority: `i_has_packet=6'b001001` (VC0 class 0, VC3 class 1) -> VC3 selected; after its `last`, VC0 selected even while VC3 stays high only if VC3 drops.
- Round-robin wrap: class 1, `i_has_packet=6'b111000`, `cts`/`last` each packet -> grant order 3,4,5,3.
- Withdraw: in REQ on VC4, drop `i_has_packet[4]`, no `cts` -> IDLE next cycle, `rr_ptr[1]` unchanged, next grant is VC4 again when re-asserted.
- Ignored events:
  - `last` in IDLE/REQ: no state change.
  - `cts` in GRANTED: no effect.
  - `cts` and `last` together in REQ: GRANTED, stays until a later `last`.
- Async reset mid-GRANTED: assert `reset` between edges -> `o_granted`/`o_request` 0 immediately; pointers 0; first post-reset grant of `6'b000011` is VC0.
